// File: rtl/mem_pkg.sv
// Shared encodings for the memory/writeback stage: writeback source select,
// load/store size codes, FSM states and the access legality check.
package mem_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_CSR = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Unsigned size codes only make sense for loads, so a store using one is illegal.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off,
                                       input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        if (is_store && f3[2]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Extracts the addressed byte/half/word from a memory read word and
// sign- or zero-extends it according to the load size code.
import mem_pkg::*;

module load_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rdata[{offset, 3'b000} +: 8];
        half_s = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_H:    data = {{(XLEN-16){half_s[15]}}, half_s};
            F3_BU:   data = {{(XLEN-8){1'b0}}, byte_s};
            F3_HU:   data = {{(XLEN-16){1'b0}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: drives a variable-latency data-memory
// handshake, stalls upstream while an access is outstanding, and writes back.
import mem_pkg::*;

module mem_wb_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            register_write_in,
    input  logic            write_enable_in,
    input  logic            read_enable_in,
    input  logic [1:0]      writeback_sel_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] csr_rdata_in,
    input  logic [4:0]      rd_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wmask,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            misaligned,
    output logic            bus_error,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;

    logic              access, cur_we, cur_ok;
    logic [1:0]        cur_off;
    logic [XLEN-1:0]   cur_addr, cur_wdata;
    logic [3:0]        cur_wmask;

    logic              req, we, stl, mis, berr, wr_en;
    logic [XLEN-1:0]   addr, wdata, wb_data, load_data;
    logic [3:0]        wmask;
    logic [4:0]        rd_sel;
    logic [2:0]        f3_sel;
    logic [1:0]        off_sel;

    // Decode of the access currently presented by the execute register.
    always_comb begin
        access   = read_enable_in | write_enable_in;
        cur_we   = write_enable_in & ~read_enable_in;
        cur_off  = alu_result_in[1:0];
        cur_ok   = access_ok(funct3_in, cur_off, cur_we);
        cur_addr = {alu_result_in[XLEN-1:2], 2'b00};
        case (funct3_in[1:0])
            2'b00: begin
                cur_wmask = 4'b0001 << cur_off;
                cur_wdata = {(XLEN/8){store_data_in[7:0]}};
            end
            2'b01: begin
                cur_wmask = 4'b0011 << cur_off;
                cur_wdata = {(XLEN/16){store_data_in[15:0]}};
            end
            default: begin
                cur_wmask = 4'b1111;
                cur_wdata = store_data_in;
            end
        endcase
        if (!cur_we) cur_wmask = 4'b0000;
    end

    // Access FSM; the counter holds cycles elapsed since the request was first issued.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        rd_d     = rd_q;
        req      = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        wmask    = 4'b0000;
        stl      = 1'b0;
        mis      = 1'b0;
        berr     = 1'b0;
        rd_sel   = rd_in;
        f3_sel   = funct3_in;
        off_sel  = cur_off;
        case (state_q)
            IDLE: begin
                if (access && !cur_ok) begin
                    mis = 1'b1;
                end else if (access) begin
                    req   = 1'b1;
                    we    = cur_we;
                    addr  = cur_addr;
                    wdata = cur_wdata;
                    wmask = cur_wmask;
                    if (!dmem_ack) begin
                        stl      = 1'b1;
                        state_d  = WAIT;
                        cnt_d    = CNT_W'(1);
                        addr_d   = cur_addr;
                        wdata_d  = cur_wdata;
                        wmask_d  = cur_wmask;
                        we_d     = cur_we;
                        funct3_d = funct3_in;
                        off_d    = cur_off;
                        rd_d     = rd_in;
                    end
                end
            end
            WAIT: begin
                rd_sel  = rd_q;
                f3_sel  = funct3_q;
                off_sel = off_q;
                req     = 1'b1;
                we      = we_q;
                addr    = addr_q;
                wdata   = wdata_q;
                wmask   = wmask_q;
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    req     = 1'b0;
                    berr    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stl   = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem_rdata),
        .offset (off_sel),
        .funct3 (f3_sel),
        .data   (load_data)
    );

    always_comb begin
        case (wb_sel_e'(writeback_sel_in))
            WB_ALU:  wb_data = alu_result_in;
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = pc_in + XLEN'(4);
            default: wb_data = csr_rdata_in;
        endcase
        wr_en = register_write_in & ~stl & ~mis & ~berr & (rd_sel != 5'd0);
    end

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        dmem_req   = ~rst & req;
        dmem_we    = ~rst & we;
        dmem_addr  = rst ? '0 : addr;
        dmem_wdata = rst ? '0 : wdata;
        dmem_wmask = rst ? 4'b0000 : wmask;
        stall      = ~rst & stl;
        misaligned = ~rst & mis;
        bus_error  = ~rst & berr;
        rf_we      = ~rst & wr_en;
        rf_waddr   = rst ? 5'd0 : rd_sel;
        rf_wdata   = rst ? '0 : wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= 4'b0000;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            rd_q     <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues hand-computed per-cycle
// expectations and a negedge monitor pops and compares them against the outputs.
module tb_mem_wb_stage;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            register_write_in = 1'b0;
    logic            write_enable_in = 1'b0;
    logic            read_enable_in = 1'b0;
    logic [1:0]      writeback_sel_in = 2'b00;
    logic [2:0]      funct3_in = 3'b000;
    logic [XLEN-1:0] alu_result_in = '0;
    logic [XLEN-1:0] store_data_in = '0;
    logic [XLEN-1:0] pc_in = '0;
    logic [XLEN-1:0] csr_rdata_in = '0;
    logic [4:0]      rd_in = 5'd0;
    logic            dmem_req, dmem_we;
    logic [XLEN-1:0] dmem_addr, dmem_wdata;
    logic [3:0]      dmem_wmask;
    logic            dmem_ack = 1'b0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic            stall, misaligned, bus_error, rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    mem_wb_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .register_write_in(register_write_in), .write_enable_in(write_enable_in),
        .read_enable_in(read_enable_in), .writeback_sel_in(writeback_sel_in),
        .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .pc_in(pc_in), .csr_rdata_in(csr_rdata_in),
        .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .misaligned(misaligned), .bus_error(bus_error),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          full;
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  wmask;
        logic        stall, mis, berr, rfwe;
        logic [4:0]  waddr;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input string tag);
        exp_t e;
        e.tag = tag;  e.full = 1'b0;
        e.req = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.wmask = 4'h0;
        e.stall = 1'b0; e.mis = 1'b0; e.berr = 1'b0; e.rfwe = 1'b0;
        e.waddr = 5'd0; e.wd = '0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, want);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : mon
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".req"},   32'(dmem_req),   32'(e.req));
            chk({e.tag, ".stall"}, 32'(stall),      32'(e.stall));
            chk({e.tag, ".mis"},   32'(misaligned), 32'(e.mis));
            chk({e.tag, ".berr"},  32'(bus_error),  32'(e.berr));
            chk({e.tag, ".rf_we"}, 32'(rf_we),      32'(e.rfwe));
            if (e.req || e.full) begin
                chk({e.tag, ".we"},   32'(dmem_we), 32'(e.we));
                chk({e.tag, ".addr"}, dmem_addr,    e.addr);
            end
            if (e.we || e.full) begin
                chk({e.tag, ".wdata"}, dmem_wdata,      e.wdata);
                chk({e.tag, ".wmask"}, 32'(dmem_wmask), 32'(e.wmask));
            end
            if (e.rfwe || e.full) begin
                chk({e.tag, ".waddr"}, 32'(rf_waddr), 32'(e.waddr));
                chk({e.tag, ".wdata"}, rf_wdata,      e.wd);
            end
        end
    end

    task automatic drive(input logic rw, input logic st, input logic ld, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd);
        register_write_in = rw;
        write_enable_in   = st;
        read_enable_in    = ld;
        writeback_sel_in  = sel;
        funct3_in         = f3;
        alu_result_in     = alu;
        store_data_in     = sd;
        rd_in             = rd;
    endtask

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        @(posedge clk);
        #1;

        // Reset holds every output low even with a live load and ack present.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 5'd3);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            e = mk("reset"); e.full = 1'b1; step(e);
        end
        rst = 1'b0;

        // ALU writeback, with a stray ack that must be ignored.
        drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd7);
        e = mk("alu_wb_ack"); e.rfwe = 1'b1; e.waddr = 5'd7; e.wd = 32'h1234_5678; step(e);
        dmem_ack = 1'b0;
        e = mk("alu_wb"); e.rfwe = 1'b1; e.waddr = 5'd7; e.wd = 32'h1234_5678; step(e);

        // sw with same-cycle ack.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);
        dmem_ack = 1'b1;
        e = mk("sw"); e.req = 1'b1; e.we = 1'b1; e.addr = 32'h100;
        e.wdata = 32'hDEAD_BEEF; e.wmask = 4'b1111; step(e);

        // lb 0x103, ack on the fourth cycle.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h103, 32'h0, 5'd5);
        dmem_ack = 1'b0; dmem_rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            e = mk("lb_wait"); e.req = 1'b1; e.addr = 32'h100; e.stall = 1'b1; step(e);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        e = mk("lb_ack"); e.req = 1'b1; e.addr = 32'h100; e.rfwe = 1'b1;
        e.waddr = 5'd5; e.wd = 32'hFFFF_FF80; step(e);

        // lhu 0x102, same-cycle ack.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b101, 32'h102, 32'h0, 5'd6);
        dmem_rdata = 32'hBEEF_1234;
        e = mk("lhu"); e.req = 1'b1; e.addr = 32'h100; e.rfwe = 1'b1;
        e.waddr = 5'd6; e.wd = 32'h0000_BEEF; step(e);

        // Misaligned / illegal accesses issue nothing.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b001, 32'h101, 32'h0, 5'd6);
        e = mk("lh_mis"); e.mis = 1'b1; step(e);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h102, 32'h0, 5'd6);
        e = mk("lw_mis"); e.mis = 1'b1; step(e);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b011, 32'h100, 32'h0, 5'd6);
        e = mk("ld_illegal"); e.mis = 1'b1; step(e);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b100, 32'h100, 32'h55, 5'd0);
        e = mk("sbu_illegal"); e.mis = 1'b1; step(e);

        // sb / sh lane replication.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h21, 32'h0000_00AB, 5'd0);
        e = mk("sb"); e.req = 1'b1; e.we = 1'b1; e.addr = 32'h20;
        e.wdata = 32'hABAB_ABAB; e.wmask = 4'b0010; step(e);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h22, 32'h1234_CAFE, 5'd0);
        e = mk("sh"); e.req = 1'b1; e.we = 1'b1; e.addr = 32'h20;
        e.wdata = 32'hCAFE_CAFE; e.wmask = 4'b1100; step(e);

        // Load that never gets an ack times out.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h200, 32'h0, 5'd9);
        dmem_ack = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            e = mk("tmo_wait"); e.req = 1'b1; e.addr = 32'h200; e.stall = 1'b1; step(e);
        end
        e = mk("tmo_berr"); e.berr = 1'b1; step(e);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        e = mk("tmo_idle"); e.full = 1'b1; step(e);

        // Reset in WAIT, then a late ack.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h300, 32'h0, 5'd10);
        for (int i = 0; i < 2; i++) begin
            e = mk("rw_wait"); e.req = 1'b1; e.addr = 32'h300; e.stall = 1'b1; step(e);
        end
        rst = 1'b1;
        e = mk("rw_rst"); e.full = 1'b1; step(e);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        e = mk("late_ack"); e.full = 1'b1; step(e);
        dmem_ack = 1'b0;

        // PC+4 wrap, rd=0 suppression, CSR source.
        pc_in = 32'hFFFF_FFFC;
        drive(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 32'h0, 32'h0, 5'd1);
        e = mk("jal"); e.rfwe = 1'b1; e.waddr = 5'd1; e.wd = 32'h0; step(e);
        drive(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 32'h0, 32'h0, 5'd0);
        e = mk("jal_rd0"); step(e);
        csr_rdata_in = 32'hA5A5_0001;
        drive(1'b1, 1'b0, 1'b0, 2'b11, 3'b000, 32'h0, 32'h0, 5'd31);
        e = mk("csr"); e.rfwe = 1'b1; e.waddr = 5'd31; e.wd = 32'hA5A5_0001; step(e);

        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
